// File: rtl/cond_unit.sv
// Condition unit: latches ALU compare flags, evaluates condition codes,
// resolves branches, issues mispredict redirects and keeps branch stats.
// Ports: clk/rst_n; cmp_valid/cmp_res compare in; cond_code/cond_use and
// cond_true for ALU csel; br_* branch resolve in; stall, redirect_valid,
// redirect_pc, br_taken out; cnt_clr, br_count, mispred_count stats.
// Option: define COND_BYPASS_EN to forward a same-cycle compare instead
// of stalling one cycle.
module cond_unit #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmp_valid,
  input  logic [1:0]         cmp_res,
  input  logic [2:0]         cond_code,
  input  logic               cond_use,
  output logic               cond_true,
  input  logic               br_valid,
  input  logic               br_pred_taken,
  input  logic [31:0]        br_target,
  input  logic [31:0]        br_fallthru,
  output logic               stall,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               br_taken,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] br_count,
  output logic [COUNT_W-1:0] mispred_count
);

  localparam int EQ = 0;
  localparam int LT = 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         flags_q, flags_d;
  logic               rv_q, rv_d;
  logic [31:0]        rpc_q, rpc_d;
  logic               bt_q, bt_d;
  logic [COUNT_W-1:0] bc_q, bc_d;
  logic [COUNT_W-1:0] mc_q, mc_d;

  logic       consumer;
  logic       hazard;
  logic       stall_c;
  logic [1:0] f_use;
  logic       ct;
  logic       resolve;
  logic       mispred;

  function automatic logic eval_cond(
    input logic [2:0] c,
    input logic [1:0] f
  );
    logic r;
    case (c)
      3'd0:    r = f[EQ];
      3'd1:    r = !f[EQ];
      3'd2:    r = f[LT];
      3'd3:    r = !f[LT];
      3'd4:    r = f[LT] | f[EQ];
      3'd5:    r = !f[LT] & !f[EQ];
      3'd6:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    consumer = cond_use | br_valid;
    hazard   = (state_q == RUN) && consumer && cmp_valid;
`ifdef COND_BYPASS_EN
    // forward the compare being produced this cycle
    f_use   = hazard ? cmp_res : flags_q;
    stall_c = 1'b0;
`else
    f_use   = flags_q;
    stall_c = hazard;
`endif
    ct      = eval_cond(cond_code, f_use);
    // wrong-path branches during REDIR are dropped
    resolve = br_valid && (state_q != REDIR) && !stall_c;
    mispred = resolve && (ct != br_pred_taken);

    flags_d = flags_q;
    if (state_q == RUN && cmp_valid)
      flags_d = cmp_res;

    rv_d  = mispred;
    rpc_d = rpc_q;
    if (mispred)
      rpc_d = ct ? br_target : br_fallthru;
    bt_d = resolve ? ct : bt_q;

    bc_d = bc_q;
    mc_d = mc_q;
    if (cnt_clr) begin
      bc_d = '0;
      mc_d = '0;
    end else begin
      if (resolve && bc_q != '1)
        bc_d = bc_q + COUNT_W'(1);
      if (mispred && mc_q != '1)
        mc_d = mc_q + COUNT_W'(1);
    end

    if (mispred)
      state_d = REDIR;
    else if (stall_c)
      state_d = HOLD;
    else
      state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      flags_q <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      bt_q    <= 1'b0;
      bc_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      bt_q    <= bt_d;
      bc_q    <= bc_d;
      mc_q    <= mc_d;
    end
  end

  assign cond_true      = ct;
  assign stall          = stall_c;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign br_taken       = bt_q;
  assign br_count       = bc_q;
  assign mispred_count  = mc_q;

endmodule

// File: tb/tb_cond_unit.sv
// Testbench for cond_unit: directed scenarios plus randomized traffic
// against a behavioural model, with COUNT_W=4 for saturation.
module tb_cond_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmp_valid;
  logic [1:0]    cmp_res;
  logic [2:0]    cond_code;
  logic          cond_use;
  logic          cond_true;
  logic          br_valid;
  logic          br_pred_taken;
  logic [31:0]   br_target;
  logic [31:0]   br_fallthru;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          br_taken;
  logic          cnt_clr;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  int checks = 0;
  int failures = 0;

  cond_unit #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmp_valid(cmp_valid), .cmp_res(cmp_res),
    .cond_code(cond_code), .cond_use(cond_use),
    .cond_true(cond_true),
    .br_valid(br_valid), .br_pred_taken(br_pred_taken),
    .br_target(br_target), .br_fallthru(br_fallthru),
    .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_taken(br_taken), .cnt_clr(cnt_clr),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  // reference model: flags, "retry pending" and "redirect cycle" markers
  bit        m_lt, m_eq;
  bit        m_hold, m_redir;
  bit        m_rv, m_bt;
  bit [31:0] m_rpc;
  int        m_bc, m_mc;

  function automatic bit m_eval(input int code, input bit lt, input bit eq);
    case (code)
      0: return eq;
      1: return !eq;
      2: return lt;
      3: return !lt;
      4: return lt || eq;
      5: return !lt && !eq;
      6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_lt = 0; m_eq = 0; m_hold = 0; m_redir = 0;
    m_rv = 0; m_bt = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic m_comb(output bit ct, output bit st);
    bit hz;
    hz = !m_redir && !m_hold && (cond_use || br_valid) && cmp_valid;
`ifdef COND_BYPASS_EN
    st = 0;
    if (hz) ct = m_eval(int'(cond_code), cmp_res[1], cmp_res[0]);
    else    ct = m_eval(int'(cond_code), m_lt, m_eq);
`else
    st = hz;
    ct = m_eval(int'(cond_code), m_lt, m_eq);
`endif
  endtask

  task automatic m_clk();
    bit ct, st, res, mis;
    m_comb(ct, st);
    res = !m_redir && br_valid && !st;
    mis = res && (ct != br_pred_taken);
    if (!m_redir && !m_hold && cmp_valid) begin
      m_lt = cmp_res[1];
      m_eq = cmp_res[0];
    end
    if (res) m_bt = ct;
    if (mis) m_rpc = ct ? br_target : br_fallthru;
    m_rv = mis;
    if (cnt_clr) begin
      m_bc = 0;
      m_mc = 0;
    end else begin
      if (res && m_bc < CMAX) m_bc = m_bc + 1;
      if (mis && m_mc < CMAX) m_mc = m_mc + 1;
    end
    m_hold = st;
    m_redir = mis;
  endtask

  task automatic idle();
    cmp_valid = 0; cmp_res = 0; cond_code = 0; cond_use = 0;
    br_valid = 0; br_pred_taken = 0; br_target = 0;
    br_fallthru = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clk();
    #1;
  endtask

  task automatic cmp_cycle(input logic [1:0] r);
    @(negedge clk);
    idle();
    cmp_valid = 1;
    cmp_res = r;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    m_reset();
    #1;
    checks++;
    if ({redirect_valid, br_taken, stall} !== 3'b000) begin
      failures++;
      $display("FAIL reset_bits got=%b want=000",
               {redirect_valid, br_taken, stall});
    end
    checks++;
    if (redirect_pc !== 32'h0 || br_count !== 0 || mispred_count !== 0) begin
      failures++;
      $display("FAIL reset_regs pc=%h bc=%0d mc=%0d want 0",
               redirect_pc, br_count, mispred_count);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_cond_codes();
    logic [7:0] exp;
    exp = 8'b0101_0110;
    @(negedge clk);
    idle();
    cond_use = 1;
    cond_code = 3'd0;
    #1;
    checks++;
    if (cond_true !== 1'b0) begin
      failures++;
      $display("FAIL eq_noflags got=%b want=0", cond_true);
    end
    cond_code = 3'd6;
    #1;
    checks++;
    if (cond_true !== 1'b1) begin
      failures++;
      $display("FAIL al got=%b want=1", cond_true);
    end
    cond_code = 3'd7;
    #1;
    checks++;
    if (cond_true !== 1'b0) begin
      failures++;
      $display("FAIL nv got=%b want=0", cond_true);
    end
    tick();
    cmp_cycle(2'b10);
    @(negedge clk);
    idle();
    cond_use = 1;
    for (int i = 0; i < 8; i++) begin
      cond_code = 3'(i);
      #1;
      checks++;
      if (cond_true !== exp[i]) begin
        failures++;
        $display("FAIL code%0d_lt got=%b want=%b", i, cond_true, exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_mispredict();
    cmp_cycle(2'b01);
    @(negedge clk);
    idle();
    br_valid = 1; cond_code = 3'd0; br_pred_taken = 0;
    br_target = 32'h100; br_fallthru = 32'h104;
    tick();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
      failures++;
      $display("FAIL redirect got=%b/%h want=1/00000100",
               redirect_valid, redirect_pc);
    end
    checks++;
    if (mispred_count !== 4'd1 || br_count !== 4'd1) begin
      failures++;
      $display("FAIL mis_counts got=%0d/%0d want=1/1",
               br_count, mispred_count);
    end
    @(negedge clk);
    br_target = 32'h300;
    tick();
    checks++;
    if (br_count !== 4'd1 || redirect_valid !== 1'b0
        || redirect_pc !== 32'h100) begin
      failures++;
      $display("FAIL redir_ignore got=%0d/%b/%h want=1/0/00000100",
               br_count, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_same_cycle();
    cmp_cycle(2'b00);
    @(negedge clk);
    idle();
    cmp_valid = 1; cmp_res = 2'b01;
    br_valid = 1; cond_code = 3'd0; br_pred_taken = 1;
    #1;
`ifdef COND_BYPASS_EN
    checks++;
    if (stall !== 1'b0 || cond_true !== 1'b1) begin
      failures++;
      $display("FAIL bypass got=%b/%b want=0/1", stall, cond_true);
    end
    tick();
`else
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL hazard_stall got=%b want=1", stall);
    end
    tick();
    checks++;
    if (br_count !== 4'd1) begin
      failures++;
      $display("FAIL stall_nocount got=%0d want=1", br_count);
    end
    @(negedge clk);
    cmp_valid = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || cond_true !== 1'b1) begin
      failures++;
      $display("FAIL hold_eval got=%b/%b want=0/1", stall, cond_true);
    end
    tick();
`endif
    checks++;
    if (redirect_valid !== 1'b0 || br_taken !== 1'b1
        || br_count !== 4'd2) begin
      failures++;
      $display("FAIL same_cycle got=%b/%b/%0d want=0/1/2",
               redirect_valid, br_taken, br_count);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    idle();
    cnt_clr = 1;
    tick();
    @(negedge clk);
    idle();
    br_valid = 1; cond_code = 3'd6; br_pred_taken = 1;
    repeat (17) tick();
    checks++;
    if (br_count !== 4'd15 || mispred_count !== 4'd0) begin
      failures++;
      $display("FAIL saturate got=%0d/%0d want=15/0",
               br_count, mispred_count);
    end
    @(negedge clk);
    cnt_clr = 1;
    tick();
    checks++;
    if (br_count !== 4'd0) begin
      failures++;
      $display("FAIL clr_beats_inc got=%0d want=0", br_count);
    end
  endtask

  task automatic test_reset_redir();
    cmp_cycle(2'b01);
    @(negedge clk);
    idle();
    br_valid = 1; cond_code = 3'd0; br_pred_taken = 0;
    br_target = 32'h200; br_fallthru = 32'h204;
    tick();
    @(negedge clk);
    idle();
    cond_use = 1; cond_code = 3'd0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || cond_true !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst got=%b/%b want=1/1", redirect_valid, cond_true);
    end
    rst_n = 0;
    m_reset();
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || cond_true !== 1'b0
        || br_count !== 0 || mispred_count !== 0 || redirect_pc !== 0) begin
      failures++;
      $display("FAIL async_rst got=%b/%b/%0d/%0d/%h want=0/0/0/0/0",
               redirect_valid, cond_true, br_count, mispred_count,
               redirect_pc);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    bit ect, est;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cmp_valid     = ($urandom_range(1) == 1);
      cmp_res       = 2'($urandom_range(3));
      cond_code     = 3'($urandom_range(7));
      cond_use      = ($urandom_range(2) == 0);
      br_valid      = ($urandom_range(4) < 2);
      br_pred_taken = ($urandom_range(1) == 1);
      br_target     = $urandom;
      br_fallthru   = $urandom;
      cnt_clr       = ($urandom_range(15) == 0);
      #1;
      m_comb(ect, est);
      checks++;
      if (cond_true !== ect || stall !== est) begin
        failures++;
        $display("FAIL rnd_comb n=%0d got=%b/%b want=%b/%b",
                 n, cond_true, stall, ect, est);
      end
      tick();
      checks++;
      if (redirect_valid !== m_rv || br_taken !== m_bt
          || redirect_pc !== m_rpc) begin
        failures++;
        $display("FAIL rnd_br n=%0d got=%b/%b/%h want=%b/%b/%h",
                 n, redirect_valid, br_taken, redirect_pc,
                 m_rv, m_bt, m_rpc);
      end
      checks++;
      if (br_count !== CW'(m_bc) || mispred_count !== CW'(m_mc)) begin
        failures++;
        $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d",
                 n, br_count, mispred_count, m_bc, m_mc);
      end
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    m_reset();
    test_reset();
    test_cond_codes();
    test_mispredict();
    test_same_cycle();
    test_saturate();
    test_reset_redir();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
